// File: rtl/ofdm_tx_pkg.sv
// Purpose: shared constants, frame config type and lookups for the OFDM TX bit pipeline.
// Latency: n/a (types, constants and functions only).
// Backpressure: n/a.
package ofdm_tx_pkg;

    // Legacy RATE field codes
    localparam logic [3:0] RATE_6  = 4'hB;
    localparam logic [3:0] RATE_9  = 4'hF;
    localparam logic [3:0] RATE_12 = 4'hA;
    localparam logic [3:0] RATE_18 = 4'hE;
    localparam logic [3:0] RATE_24 = 4'h9;
    localparam logic [3:0] RATE_36 = 4'hD;
    localparam logic [3:0] RATE_48 = 4'h8;
    localparam logic [3:0] RATE_54 = 4'hC;

    // Puncture patterns, expressed as their period in uncoded bits.
    // Phase 0 emits A,B; phase 1 emits A; phase 2 emits B.
    localparam logic [1:0] PUNC_1_2 = 2'd1;
    localparam logic [1:0] PUNC_2_3 = 2'd2;
    localparam logic [1:0] PUNC_3_4 = 2'd3;

    // K=7 generator polynomials; bit 6 is the current input, bit 0 the oldest
    localparam logic [6:0] CONV_G0 = 7'o133;
    localparam logic [6:0] CONV_G1 = 7'o171;

    // x^7 + x^4 + 1 scrambler
    localparam int         SCR_TAP_HI       = 6;
    localparam int         SCR_TAP_LO       = 3;
    localparam logic [6:0] SCR_DEFAULT_SEED = 7'h7F;

    localparam int SERVICE_BITS = 16;
    localparam int TAIL_BITS    = 6;

    // Frame FSM states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SERVICE = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_TAIL    = 3'd3;
    localparam logic [2:0] ST_PAD     = 3'd4;
    localparam logic [2:0] ST_FLUSH   = 3'd5;

    // Per-frame settings latched at start
    typedef struct packed {
        logic       raw;
        logic [1:0] punc_period;
        logic [7:0] n_dbps;
    } frame_cfg_t;

    // Data bits per OFDM symbol; unknown codes fall back to 6 Mb/s
    function automatic logic [7:0] ndbps_of(input logic [3:0] rc);
        logic [7:0] n;
        case (rc)
            RATE_9:  n = 8'd36;
            RATE_12: n = 8'd48;
            RATE_18: n = 8'd72;
            RATE_24: n = 8'd96;
            RATE_36: n = 8'd144;
            RATE_48: n = 8'd192;
            RATE_54: n = 8'd216;
            default: n = 8'd24;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] punc_period_of(input logic [3:0] rc);
        logic [1:0] p;
        case (rc)
            RATE_9, RATE_18, RATE_36, RATE_54: p = PUNC_3_4;
            RATE_48:                           p = PUNC_2_3;
            default:                           p = PUNC_1_2;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/conv_encoder_k7.sv
// Purpose: K=7 rate-1/2 convolutional encoder core (g0=133o, g1=171o), shift register plus taps.
// Latency: A/B are combinational from the current input bit; state advances on bit_vld.
// Backpressure: none; caller strobes bit_vld only when the coded pair can be accepted.
module conv_encoder_k7
    import ofdm_tx_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic bit_vld,
    input  logic bit_dat,
    output logic a_dat,
    output logic b_dat
);

    // sr_q[5] is the previous input, sr_q[0] the input six bits ago
    logic [5:0] sr_q;
    logic [6:0] win;

    assign win   = {bit_dat, sr_q};
    assign a_dat = ^(win & CONV_G0);
    assign b_dat = ^(win & CONV_G1);

    // Shift the accepted bit into the delay line; clear zeroes it at frame start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= 6'd0;
        end else if (clear) begin
            sr_q <= 6'd0;
        end else if (bit_vld) begin
            sr_q <= win[6:1];
        end
    end

endmodule

// File: rtl/ofdm_bit_encoder.sv
// Purpose: PSDU bytes -> scrambled, tailed, padded, K=7 coded and punctured bit stream.
// Latency: first bit_out_valid two cycles after an accepted start; one coded bit per cycle after that.
// Backpressure: 2-entry registered output buffer; uncoded bits advance only when their coded bits fit.
module ofdm_bit_encoder
    import ofdm_tx_pkg::*;
#(
    parameter int LEN_WIDTH = 12
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [7:0]           rate,
    input  logic [LEN_WIDTH-1:0] psdu_len,
    input  logic                 do_scramble,
    input  logic [6:0]           scramble_seed,
    input  logic [7:0]           byte_in,
    input  logic                 byte_in_valid,
    output logic                 byte_in_ready,
    output logic                 bit_out,
    output logic                 bit_out_valid,
    input  logic                 bit_out_ready,
    output logic                 busy,
    output logic                 done
);

    logic [2:0]           state_q;
    frame_cfg_t           cfg_q;
    logic [6:0]           scr_q;
    logic [1:0]           ph_q;
    logic [7:0]           sym_q;
    logic [3:0]           ctr_q;
    logic [LEN_WIDTH-1:0] bytes_left_q;
    logic [2:0]           bits_left_q;
    logic [6:0]           sh_q;
    logic                 obuf0_q;
    logic                 obuf1_q;
    logic [1:0]           ocnt_q;
    logic                 done_q;

    logic       start_acc, in_frame, need_byte, avail, src_bit, fb, enc_bit;
    logic       enc_a, enc_b, pop, fits, adv, push0, push1, last_phase;
    logic [1:0] keep, n_push;
    logic [7:0] sym_nxt;
    logic       rate_hi_unused;

    assign rate_hi_unused = ^rate[7:4];

    assign start_acc = start && (state_q == ST_IDLE);
    assign in_frame  = (state_q == ST_SERVICE) || (state_q == ST_PAYLOAD) ||
                       (state_q == ST_TAIL)    || (state_q == ST_PAD);

    // A fresh byte's bit 0 is fed straight through so no cycle is lost on load
    assign need_byte = (state_q == ST_PAYLOAD) && (bits_left_q == 3'd0);
    assign avail     = !need_byte || byte_in_valid;
    assign src_bit   = (state_q == ST_PAYLOAD) ? (need_byte ? byte_in[0] : sh_q[0]) : 1'b0;

    // Tail bits enter the encoder as zero even though the scrambler keeps stepping
    assign fb      = scr_q[SCR_TAP_HI] ^ scr_q[SCR_TAP_LO];
    assign enc_bit = cfg_q.raw ? src_bit : ((state_q == ST_TAIL) ? 1'b0 : (src_bit ^ fb));

    // Punctured outputs of the current uncoded bit, in emission order
    assign n_push = (ph_q == 2'd0) ? 2'd2 : 2'd1;
    assign push0  = (ph_q == 2'd2) ? enc_b : enc_a;
    assign push1  = enc_b;

    // Space check counts a bit leaving this cycle so a full-rate stream has no bubbles
    assign pop   = (ocnt_q != 2'd0) && bit_out_ready;
    assign keep  = ocnt_q - {1'b0, pop};
    assign fits  = ({1'b0, keep} + {1'b0, n_push}) <= 3'd2;
    assign adv   = in_frame && avail && fits;

    assign byte_in_ready = need_byte && byte_in_valid && fits;

    assign sym_nxt    = (sym_q == cfg_q.n_dbps - 8'd1) ? 8'd0 : sym_q + 8'd1;
    assign last_phase = (ph_q == cfg_q.punc_period - 2'd1);

    assign bit_out       = obuf0_q;
    assign bit_out_valid = (ocnt_q != 2'd0);
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

    conv_encoder_k7 u_enc (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start_acc),
        .bit_vld (adv),
        .bit_dat (enc_bit),
        .a_dat   (enc_a),
        .b_dat   (enc_b)
    );

    // Output buffer: drop the accepted head, then append this cycle's punctured bits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            obuf0_q <= 1'b0;
            obuf1_q <= 1'b0;
            ocnt_q  <= 2'd0;
        end else if (pop || adv) begin
            if (keep == 2'd1) begin
                obuf0_q <= pop ? obuf1_q : obuf0_q;
                obuf1_q <= push0;
            end else if (keep == 2'd0) begin
                obuf0_q <= push0;
                obuf1_q <= push1;
            end
            ocnt_q <= keep + (adv ? n_push : 2'd0);
        end
    end

    // Frame sequencing, serialiser, scrambler, symbol and puncture counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cfg_q        <= '0;
            scr_q        <= 7'd0;
            ph_q         <= 2'd0;
            sym_q        <= 8'd0;
            ctr_q        <= 4'd0;
            bytes_left_q <= '0;
            bits_left_q  <= 3'd0;
            sh_q         <= 7'd0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_acc) begin
                cfg_q.raw         <= !do_scramble;
                cfg_q.punc_period <= do_scramble ? punc_period_of(rate[3:0]) : PUNC_1_2;
                cfg_q.n_dbps      <= ndbps_of(rate[3:0]);
                scr_q             <= (scramble_seed == 7'd0) ? SCR_DEFAULT_SEED : scramble_seed;
                ph_q              <= 2'd0;
                sym_q             <= 8'd0;
                ctr_q             <= 4'd0;
                bytes_left_q      <= psdu_len;
                bits_left_q       <= 3'd0;
                if (do_scramble)
                    state_q <= ST_SERVICE;
                else
                    state_q <= (psdu_len == '0) ? ST_FLUSH : ST_PAYLOAD;
            end else if (adv) begin
                scr_q <= {scr_q[5:0], fb};
                ph_q  <= last_phase ? 2'd0 : ph_q + 2'd1;
                sym_q <= sym_nxt;
                case (state_q)
                    ST_SERVICE: begin
                        ctr_q <= ctr_q + 4'd1;
                        if (ctr_q == 4'(SERVICE_BITS - 1)) begin
                            ctr_q   <= 4'd0;
                            state_q <= (bytes_left_q == '0) ? ST_TAIL : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (need_byte) begin
                            sh_q         <= byte_in[7:1];
                            bits_left_q  <= 3'd7;
                            bytes_left_q <= bytes_left_q - 1'b1;
                        end else begin
                            sh_q        <= {1'b0, sh_q[6:1]};
                            bits_left_q <= bits_left_q - 3'd1;
                            if (bits_left_q == 3'd1 && bytes_left_q == '0)
                                state_q <= cfg_q.raw ? ST_FLUSH : ST_TAIL;
                        end
                    end
                    ST_TAIL: begin
                        ctr_q <= ctr_q + 4'd1;
                        if (ctr_q == 4'(TAIL_BITS - 1)) begin
                            ctr_q   <= 4'd0;
                            state_q <= (sym_nxt == 8'd0) ? ST_FLUSH : ST_PAD;
                        end
                    end
                    default: begin
                        if (sym_nxt == 8'd0)
                            state_q <= ST_FLUSH;
                    end
                endcase
            end else if (state_q == ST_FLUSH &&
                         (ocnt_q == 2'd0 || (ocnt_q == 2'd1 && pop))) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ofdm_bit_encoder.sv
// Purpose: randomized self-checking bench for ofdm_bit_encoder against a frame-level reference model.
// Latency: checks first coded bit two cycles after start.
// Backpressure: drives random bit_out_ready and gapped byte_in_valid.
module tb_ofdm_bit_encoder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rate = 8'h0B;
    logic [11:0] psdu_len = 12'd0;
    logic        do_scramble = 1'b0;
    logic [6:0]  scramble_seed = 7'd0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_in_valid = 1'b0;
    logic        byte_in_ready;
    logic        bit_out;
    logic        bit_out_valid;
    logic        bit_out_ready = 1'b1;
    logic        busy;
    logic        done;

    always #5 clock = ~clock;

    ofdm_bit_encoder #(.LEN_WIDTH(12)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .rate          (rate),
        .psdu_len      (psdu_len),
        .do_scramble   (do_scramble),
        .scramble_seed (scramble_seed),
        .byte_in       (byte_in),
        .byte_in_valid (byte_in_valid),
        .byte_in_ready (byte_in_ready),
        .bit_out       (bit_out),
        .bit_out_valid (bit_out_valid),
        .bit_out_ready (bit_out_ready),
        .busy          (busy),
        .done          (done)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] pay [0:4095];
    bit         got_q[$];
    bit         exp_q[$];
    bit         ref_q[$];
    int         done_cnt;
    int         first_vld;
    int         hold_err;
    int         fin_flag;
    logic [3:0] rate_tbl [9] = '{4'hB, 4'hF, 4'hA, 4'hE, 4'h9, 4'hD, 4'h8, 4'hC, 4'h3};

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic int tb_ndbps(input logic [3:0] r);
        case (r)
            4'hF: return 36;
            4'hA: return 48;
            4'hE: return 72;
            4'h9: return 96;
            4'hD: return 144;
            4'h8: return 192;
            4'hC: return 216;
            default: return 24;
        endcase
    endfunction

    function automatic int tb_period(input logic [3:0] r);
        case (r)
            4'h8: return 2;
            4'hF, 4'hE, 4'hD, 4'hC: return 3;
            default: return 1;
        endcase
    endfunction

    // Whole-frame model: build the uncoded bit list, scramble it as a sequence,
    // convolve with the generator taps, then puncture by bit index.
    task automatic build_exp(input bit raw_m, input logic [3:0] rc, input int len,
                             input logic [6:0] seed);
        bit         u[$];
        bit         z[$];
        bit         d[7];
        logic [6:0] s;
        int         tail0, per, k3;
        bit         a, b;
        exp_q.delete();
        if (!raw_m) repeat (16) u.push_back(1'b0);
        for (int i = 0; i < len; i++)
            for (int j = 0; j < 8; j++) u.push_back(pay[i][j]);
        tail0 = u.size();
        if (!raw_m) begin
            repeat (6) u.push_back(1'b0);
            while (u.size() % tb_ndbps(rc) != 0) u.push_back(1'b0);
            s = (seed == 7'd0) ? 7'h7F : seed;
            for (int i = 0; i < 7; i++) z.push_back(s[6-i]);
            for (int k = 0; k < u.size(); k++) begin
                z.push_back(z[k] ^ z[k+3]);
                if (k >= tail0 && k < tail0 + 6) u[k] = 1'b0;
                else u[k] = u[k] ^ z[k+7];
            end
        end
        per = raw_m ? 1 : tb_period(rc);
        for (int k = 0; k < u.size(); k++) begin
            for (int t = 0; t < 7; t++) d[t] = (k - t >= 0) ? u[k-t] : 1'b0;
            a  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
            b  = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[6];
            k3 = k % per;
            if (k3 == 0) begin exp_q.push_back(a); exp_q.push_back(b); end
            else if (k3 == 1) exp_q.push_back(a);
            else exp_q.push_back(b);
        end
    endtask

    task automatic run_frame(input bit raw_m, input logic [7:0] rc, input int len,
                             input logic [6:0] seed, input bit rnd);
        int bidx = 0;
        int cyc = 0;
        bit pv = 1'b0, pr = 1'b0, pb = 1'b0;
        got_q.delete();
        done_cnt = 0; first_vld = -1; hold_err = 0; fin_flag = 0;
        @(negedge clock);
        start = 1'b1; rate = rc; psdu_len = len[11:0]; do_scramble = !raw_m;
        scramble_seed = seed; byte_in_valid = 1'b0; bit_out_ready = 1'b1;
        @(negedge clock);
        while (fin_flag == 0 && cyc < 20000) begin
            if (cyc == 30 && busy) begin
                start = 1'b1; rate = 8'($urandom); psdu_len = 12'($urandom);
                do_scramble = 1'($urandom); scramble_seed = 7'($urandom);
            end else begin
                start = 1'b0;
            end
            bit_out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            byte_in_valid = (bidx < len) && (!rnd || $urandom_range(0, 2) != 0);
            byte_in       = (bidx < len) ? pay[bidx] : 8'h00;
            #1;
            if (pv && !pr && (!bit_out_valid || bit_out != pb)) hold_err++;
            pv = bit_out_valid; pr = bit_out_ready; pb = bit_out;
            if (bit_out_valid && first_vld < 0) first_vld = cyc;
            if (bit_out_valid && bit_out_ready) got_q.push_back(bit_out);
            if (byte_in_valid && byte_in_ready) bidx++;
            if (done) begin done_cnt++; fin_flag = 1; end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0; byte_in_valid = 1'b0; bit_out_ready = 1'b1;
        check("frame_finished", fin_flag, 1);
        repeat (4) begin
            #1;
            if (done) done_cnt++;
            @(negedge clock);
        end
    endtask

    task automatic check_frame(input string tag);
        int diff = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (diff < 0 && got_q[i] !== exp_q[i]) diff = i;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        check({tag, "_first_diff"}, diff, -1);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_hold"}, hold_err, 0);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        logic [13:0] head;
        int          ones, diff, len;
        bit          rm;
        logic [7:0]  rc;
        logic [6:0]  sd;

        repeat (3) @(negedge clock);
        #1;
        check("rst_valid", bit_out_valid, 0);
        check("rst_bit", bit_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_byte_rdy", byte_in_ready, 0);
        reset_n = 1'b1;

        // Raw mode impulse: bit 0 of the first byte set
        pay[0] = 8'h01; pay[1] = 8'h00; pay[2] = 8'h00;
        build_exp(1'b1, 4'hB, 3, 7'd0);
        run_frame(1'b1, 8'h0B, 3, 7'd0, 1'b0);
        check_frame("raw");
        head = '0; ones = 0;
        for (int i = 0; i < 14 && i < got_q.size(); i++) head = {head[12:0], got_q[i]};
        for (int i = 14; i < got_q.size(); i++) ones += got_q[i];
        check("raw_head", head, 14'b11011111001011);
        check("raw_rest_zero", ones, 0);
        check("raw_total", got_q.size(), 48);
        check("raw_first_vld", first_vld, 1);

        // Empty PSDU, default seed: SERVICE scrambles to 0000111 0...
        build_exp(1'b0, 4'hB, 0, 7'h7F);
        run_frame(1'b0, 8'h0B, 0, 7'h7F, 1'b0);
        check_frame("len0");
        head = '0;
        for (int i = 0; i < 14 && i < got_q.size(); i++) head = {head[12:0], got_q[i]};
        check("len0_head", head, 14'b00000000111001);
        check("len0_total", got_q.size(), 48);
        check("len0_first_vld", first_vld, 1);

        // 100-byte frames at three rates
        for (int i = 0; i < 100; i++) pay[i] = 8'($urandom);
        build_exp(1'b0, 4'hB, 100, 7'h2B);
        run_frame(1'b0, 8'h0B, 100, 7'h2B, 1'b0);
        check_frame("b100");
        check("b100_total", got_q.size(), 1680);
        ref_q = got_q;

        build_exp(1'b0, 4'hC, 100, 7'h11);
        run_frame(1'b0, 8'h0C, 100, 7'h11, 1'b0);
        check_frame("c100");
        check("c100_total", got_q.size(), 1152);

        build_exp(1'b0, 4'h8, 100, 7'h11);
        run_frame(1'b0, 8'h08, 100, 7'h11, 1'b0);
        check_frame("r8_100");
        check("r8_100_total", got_q.size(), 1440);

        // Same B frame under random backpressure and gapped input must match exactly
        build_exp(1'b0, 4'hB, 100, 7'h2B);
        run_frame(1'b0, 8'h0B, 100, 7'h2B, 1'b1);
        check_frame("b100_rnd");
        diff = -1;
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            if (diff < 0 && got_q[i] !== ref_q[i]) diff = i;
        check("b100_rnd_vs_ref_len", got_q.size(), ref_q.size());
        check("b100_rnd_vs_ref_diff", diff, -1);

        // Random frames: all rates, undefined codes, raw mode, zero seeds
        for (int f = 0; f < 8; f++) begin
            rm  = ($urandom_range(0, 3) == 0);
            rc  = {4'($urandom), rate_tbl[$urandom_range(0, 8)]};
            len = $urandom_range(0, 40);
            sd  = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            build_exp(rm, rc[3:0], len, sd);
            run_frame(rm, rc, len, sd, 1'b1);
            check_frame("rand");
        end

        // Reset in the middle of the payload, then a clean frame
        @(negedge clock);
        start = 1'b1; rate = 8'h0B; psdu_len = 12'd50; do_scramble = 1'b1;
        scramble_seed = 7'h5A; bit_out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0; byte_in_valid = 1'b1; byte_in = 8'hA5;
        repeat (60) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valid", bit_out_valid, 0);
        check("midrst_bit", bit_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_byte_rdy", byte_in_ready, 0);
        check("midrst_done", done, 0);
        @(negedge clock);
        reset_n = 1'b1; byte_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
        build_exp(1'b0, 4'hE, 20, 7'h33);
        run_frame(1'b0, 8'h0E, 20, 7'h33, 1'b0);
        check_frame("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
